// File: rtl/fetch_hazard_ctrl_if.sv
// fetch_hazard_ctrl_if
// Bundles the pipeline-side signals of the fetch/hazard controller.
//   From the pipeline:   id_inst, ex_rd, ex_mem_read, ex_bch_taken, ex_bch_tgt
//   To the fetch stage:  pc_en, stall_en, jmp_bch_en, jmp_bch_tgt
//   To the pipe regs:    if_id_en, if_id_flush, id_ex_flush
// Modports: master = controller side, slave = pipeline side.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface fetch_hazard_ctrl_if #(
    parameter int addr_width = `MEM_ADDR_WIDTH,
    parameter int word_width = `WORD_WIDTH
);
    logic [word_width-1:0] id_inst;
    logic [4:0]            ex_rd;
    logic                  ex_mem_read;
    logic                  ex_bch_taken;
    logic [addr_width-1:0] ex_bch_tgt;

    logic                  pc_en;
    logic                  stall_en;
    logic                  jmp_bch_en;
    logic [addr_width-1:0] jmp_bch_tgt;
    logic                  if_id_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;

    modport master (
        input  id_inst, ex_rd, ex_mem_read, ex_bch_taken, ex_bch_tgt,
        output pc_en, stall_en, jmp_bch_en, jmp_bch_tgt,
               if_id_en, if_id_flush, id_ex_flush
    );

    modport slave (
        output id_inst, ex_rd, ex_mem_read, ex_bch_taken, ex_bch_tgt,
        input  pc_en, stall_en, jmp_bch_en, jmp_bch_tgt,
               if_id_en, if_id_flush, id_ex_flush
    );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl
// Sequencing controller for the fetch stage and the IF/ID and ID/EX pipeline
// registers: load-use stall detection, redirect squashing with NOP-fetch
// slots, debug halt/resume, saturating stall/flush event counters.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   bus             fetch_hazard_ctrl_if.master (pipeline inputs, fetch and
//                   pipe-register controls)
//   halt_req        debug halt request (level)
//   resume          debug resume (pulse)
//   halted          controller is in HALT
//   stall_cnt       saturating count of load-use stall cycles
//   flush_cnt       saturating count of taken redirects
//
// state | meaning
// ------+----------------------------------------------------------
// BOOT  | one cycle after reset: PC frozen, pipe regs loaded with NOPs
// RUN   | normal fetch; redirect / load-use / halt decisions made here
// FLUSH | NOP fetches after a redirect, slot_q counts them down
// HALT  | debug halt, PC frozen, bubbles into EX until resume

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module fetch_hazard_ctrl #(
    parameter int addr_width  = `MEM_ADDR_WIDTH,
    parameter int word_width  = `WORD_WIDTH,
    parameter int FLUSH_SLOTS = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_hazard_ctrl_if.master  bus,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [2:0] SLOTS = 3'(FLUSH_SLOTS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [2:0]           slot_q, slot_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       uses_rs1, uses_rs2, load_use;
    logic       stall_inc, flush_inc;

    // Only the opcode and source-register fields matter for hazard detection.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{bus.id_inst[word_width-1:25], bus.id_inst[14:7]};

    assign opcode = bus.id_inst[6:0];
    assign rs1    = bus.id_inst[19:15];
    assign rs2    = bus.id_inst[24:20];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            7'b0110011, 7'b1100011, 7'b0100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((uses_rs1 && (bus.ex_rd == rs1)) ||
                       (uses_rs2 && (bus.ex_rd == rs2)));

    assign bus.jmp_bch_tgt = bus.ex_bch_tgt;

    always_comb begin
        bus.pc_en       = 1'b0;
        bus.stall_en    = 1'b0;
        bus.jmp_bch_en  = 1'b0;
        bus.if_id_en    = 1'b0;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        halted          = 1'b0;
        state_d         = state_q;
        slot_d          = slot_q;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;

        case (state_q)
            ST_BOOT: begin
                bus.stall_en    = 1'b1;
                bus.if_id_flush = 1'b1;
                bus.id_ex_flush = 1'b1;
                state_d         = ST_RUN;
            end
            ST_RUN: begin
                if (bus.ex_bch_taken) begin
                    // Redirect wins over a same-cycle load-use: the stalled
                    // instruction is on the wrong path and is squashed anyway.
                    bus.jmp_bch_en  = 1'b1;
                    bus.pc_en       = 1'b1;
                    bus.if_id_flush = 1'b1;
                    bus.id_ex_flush = 1'b1;
                    flush_inc       = 1'b1;
                    if (SLOTS != 3'd0) begin
                        state_d = ST_FLUSH;
                        slot_d  = SLOTS;
                    end
                end else if (load_use) begin
                    bus.id_ex_flush = 1'b1;
                    stall_inc       = 1'b1;
                end else begin
                    bus.pc_en    = 1'b1;
                    bus.if_id_en = 1'b1;
                    if (halt_req) state_d = ST_HALT;
                end
            end
            ST_FLUSH: begin
                // Only bubbles are in EX here, so ex_bch_taken cannot be real.
                bus.pc_en    = 1'b1;
                bus.stall_en = 1'b1;
                bus.if_id_en = 1'b1;
                slot_d       = slot_q - 3'd1;
                if (slot_q <= 3'd1) begin
                    state_d = ST_RUN;
                    slot_d  = 3'd0;
                end
            end
            default: begin
                bus.stall_en    = 1'b1;
                bus.id_ex_flush = 1'b1;
                halted          = 1'b1;
                if (resume) state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush_inc && (flush_cnt_q != {CNT_WIDTH{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            slot_q      <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
module tb_fetch_hazard_ctrl;
    localparam int AW = 32;
    localparam int WW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [WW-1:0] id_inst;
    logic [4:0]    ex_rd;
    logic          ex_mem_read, ex_bch_taken;
    logic [AW-1:0] ex_bch_tgt;
    logic          halt_req, resume;

    fetch_hazard_ctrl_if #(.addr_width(AW), .word_width(WW)) bus0 ();
    fetch_hazard_ctrl_if #(.addr_width(AW), .word_width(WW)) bus1 ();

    assign bus0.id_inst = id_inst;      assign bus1.id_inst = id_inst;
    assign bus0.ex_rd = ex_rd;          assign bus1.ex_rd = ex_rd;
    assign bus0.ex_mem_read = ex_mem_read;   assign bus1.ex_mem_read = ex_mem_read;
    assign bus0.ex_bch_taken = ex_bch_taken; assign bus1.ex_bch_taken = ex_bch_taken;
    assign bus0.ex_bch_tgt = ex_bch_tgt;     assign bus1.ex_bch_tgt = ex_bch_tgt;

    logic        halted0, halted1;
    logic [15:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    fetch_hazard_ctrl #(.addr_width(AW), .word_width(WW), .FLUSH_SLOTS(1), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .halt_req(halt_req), .resume(resume),
        .halted(halted0), .stall_cnt(sc0), .flush_cnt(fc0));

    fetch_hazard_ctrl #(.addr_width(AW), .word_width(WW), .FLUSH_SLOTS(3), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .halt_req(halt_req), .resume(resume),
        .halted(halted1), .stall_cnt(sc1), .flush_cnt(fc1));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each controller is described by: booting flag, halted flag, number of
    // NOP fetches still owed after a redirect, and the two event totals.
    int m_boot [2] = '{1, 1};
    int m_halt [2] = '{0, 0};
    int m_owed [2] = '{0, 0};
    int m_sc   [2] = '{0, 0};
    int m_fc   [2] = '{0, 0};
    int p_slots[2] = '{1, 3};
    int p_max  [2] = '{65535, 15};

    function automatic int num_src(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b1100011, 7'b0100011: return 2;
            7'b0010011, 7'b0000011, 7'b1100111: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_lu();
        int n;
        int r1, r2;
        n  = num_src(id_inst[6:0]);
        r1 = int'(id_inst[19:15]);
        r2 = int'(id_inst[24:20]);
        if (!ex_mem_read || ex_rd == 5'd0) return 0;
        return (n >= 1 && int'(ex_rd) == r1) || (n == 2 && int'(ex_rd) == r2);
    endfunction

    // {pc_en, stall_en, jmp_bch_en, if_id_en, if_id_flush, id_ex_flush, halted}
    function automatic logic [6:0] model_out(input int k);
        if (m_boot[k] != 0)      return 7'b0100110;
        else if (m_halt[k] != 0) return 7'b0100011;
        else if (m_owed[k] > 0)  return 7'b1101000;
        else if (ex_bch_taken)   return 7'b1010110;
        else if (model_lu())     return 7'b0000010;
        else                     return 7'b1001000;
    endfunction

    function automatic logic [6:0] dut_out(input int k);
        if (k == 0)
            return {bus0.pc_en, bus0.stall_en, bus0.jmp_bch_en, bus0.if_id_en,
                    bus0.if_id_flush, bus0.id_ex_flush, halted0};
        return {bus1.pc_en, bus1.stall_en, bus1.jmp_bch_en, bus1.if_id_en,
                bus1.if_id_flush, bus1.id_ex_flush, halted1};
    endfunction

    task automatic model_advance(input int k);
        bit lu;
        lu = model_lu();
        if (rst) begin
            m_boot[k] = 1; m_halt[k] = 0; m_owed[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end else if (m_boot[k] != 0) begin
            m_boot[k] = 0;
        end else if (m_halt[k] != 0) begin
            if (resume) m_halt[k] = 0;
        end else if (m_owed[k] > 0) begin
            m_owed[k]--;
        end else if (ex_bch_taken) begin
            m_owed[k] = p_slots[k];
            if (m_fc[k] < p_max[k]) m_fc[k]++;
        end else if (lu) begin
            if (m_sc[k] < p_max[k]) m_sc[k]++;
        end else if (halt_req) begin
            m_halt[k] = 1;
        end
    endtask

    // Called with inputs settled just after a falling edge: compare both DUTs
    // to the model, advance the model across the coming rising edge.
    task automatic step();
        #1;
        if (!rst) begin
            chk("ctrl0", dut_out(0), model_out(0));
            chk("ctrl1", dut_out(1), model_out(1));
            chk("tgt0", bus0.jmp_bch_tgt, ex_bch_tgt);
            chk("stall_cnt0", sc0, m_sc[0]);
            chk("flush_cnt0", fc0, m_fc[0]);
            chk("stall_cnt1", sc1, m_sc[1]);
            chk("flush_cnt1", fc1, m_fc[1]);
        end
        model_advance(0);
        model_advance(1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int r1, input int r2);
        return {7'b0, 5'(r2), 5'(r1), 3'b0, 5'(rd), op};
    endfunction

    task automatic idle();
        ex_mem_read = 0; ex_bch_taken = 0; halt_req = 0; resume = 0;
        ex_rd = 0; id_inst = 32'h0000_0013; ex_bch_tgt = 32'h0;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        mr;
        logic        e_pc;
        logic        e_ifid;
        logic        e_idex;
    } vec_t;

    vec_t vt[12];
    int   stall_before;
    logic [6:0] ops[9] = '{7'b0110011, 7'b1100011, 7'b0100011, 7'b0010011,
                          7'b0000011, 7'b1100111, 7'b0110111, 7'b1101111, 7'b1110011};

    initial begin
        vt[0]  = '{mk(7'b0110011, 1, 2, 3), 5'd2, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{mk(7'b0110011, 1, 2, 3), 5'd3, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{mk(7'b0100011, 0, 4, 6), 5'd6, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{mk(7'b1100011, 0, 1, 7), 5'd7, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{mk(7'b0010011, 1, 8, 9), 5'd9, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5]  = '{mk(7'b0010011, 1, 8, 9), 5'd8, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{mk(7'b0000011, 1, 10, 0), 5'd10, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{mk(7'b1100111, 1, 11, 0), 5'd11, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{mk(7'b1101111, 12, 12, 12), 5'd12, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[9]  = '{mk(7'b0010111, 13, 13, 13), 5'd13, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[10] = '{mk(7'b0110011, 1, 2, 3), 5'd2, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[11] = '{mk(7'b1110011, 1, 14, 15), 5'd14, 1'b1, 1'b1, 1'b1, 1'b0};

        idle();
        rst = 1;
        @(negedge clk);

        // Reset held 3 cycles, then exactly one BOOT cycle.
        repeat (3) step();
        rst = 0;
        #1;
        chk("boot_pc_en", bus0.pc_en, 0);
        chk("boot_stall_en", bus0.stall_en, 1);
        chk("boot_flushes", {bus0.if_id_flush, bus0.id_ex_flush}, 2'b11);
        chk("boot_cnts", {sc0, fc0}, 0);
        step();
        #1 chk("run_pc_en", bus0.pc_en, 1);
        step();

        // Load-use: one-cycle stall, then the bubble clears ex_mem_read.
        ex_mem_read = 1; ex_rd = 5; id_inst = mk(7'b0110011, 6, 5, 7);
        #1 chk("lu_ctrl", {bus0.pc_en, bus0.if_id_en, bus0.id_ex_flush}, 3'b001);
        step();
        ex_mem_read = 0;
        #1 chk("lu_release_pc", bus0.pc_en, 1);
        chk("lu_stall_cnt", sc0, 1);
        step();
        ex_mem_read = 1; ex_rd = 5; id_inst = mk(7'b0110111, 5, 0, 0);
        #1 chk("lui_no_stall", bus0.pc_en, 1);
        step();
        ex_rd = 0; id_inst = mk(7'b0110011, 6, 0, 7);
        #1 chk("x0_no_stall", bus0.pc_en, 1);
        step();
        #1 chk("no_stall_cnt", sc0, 1);

        // Redirect with one NOP-fetch slot.
        idle();
        ex_bch_taken = 1; ex_bch_tgt = 32'h40;
        #1 chk("redir_ctrl", {bus0.jmp_bch_en, bus0.pc_en, bus0.if_id_flush, bus0.id_ex_flush}, 4'hF);
        chk("redir_tgt", bus0.jmp_bch_tgt, 32'h40);
        step();
        ex_bch_taken = 0;
        #1 chk("flush_slot", {bus0.stall_en, bus0.pc_en, bus0.jmp_bch_en}, 3'b110);
        step();
        #1 chk("after_flush", {bus0.stall_en, bus0.pc_en}, 2'b01);
        chk("flush_cnt", fc0, 1);
        step();

        // Redirect together with a load-use condition.
        ex_bch_taken = 1; ex_bch_tgt = 32'h80;
        ex_mem_read = 1; ex_rd = 5; id_inst = mk(7'b0110011, 6, 5, 7);
        #1 chk("sim_ctrl", {bus0.jmp_bch_en, bus0.pc_en}, 2'b11);
        step();
        idle();
        #1 chk("sim_stall_cnt", sc0, 1);
        chk("sim_flush_cnt", fc0, 2);
        step();
        step();

        // Halt, hold 5 cycles, resume.
        halt_req = 1;
        #1 chk("halt_req_cycle", {bus0.pc_en, halted0}, 2'b10);
        step();
        halt_req = 0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("halted", {halted0, bus0.pc_en, bus0.stall_en, bus0.id_ex_flush}, 4'b1011);
            step();
        end
        resume = 1;
        step();
        resume = 0;
        #1 chk("resumed", {bus0.pc_en, halted0}, 2'b10);
        step();
        repeat (3) step();

        // Table of single-cycle decode vectors applied in RUN.
        for (int i = 0; i < 12; i++) begin
            idle();
            id_inst = vt[i].inst; ex_rd = vt[i].rd; ex_mem_read = vt[i].mr;
            #1 chk($sformatf("vec%0d", i), {bus0.pc_en, bus0.if_id_en, bus0.id_ex_flush},
                   {vt[i].e_pc, vt[i].e_ifid, vt[i].e_idex});
            step();
        end
        idle();
        repeat (4) step();

        // Saturation of the 4-bit counter: 2^4+3 consecutive stalls.
        stall_before = int'(sc0);
        ex_mem_read = 1; ex_rd = 5; id_inst = mk(7'b0110011, 6, 5, 7);
        repeat (19) step();
        idle();
        #1 chk("sat_stall_cnt1", sc1, 4'hF);
        chk("nosat_stall_cnt0", sc0, stall_before + 19);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            ex_bch_taken = ($urandom_range(0, 7) == 0);
            halt_req     = ($urandom_range(0, 15) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            ex_mem_read  = $urandom_range(0, 1) == 1;
            ex_rd        = 5'($urandom_range(0, 3));
            ex_bch_tgt   = $urandom;
            id_inst      = $urandom;
            id_inst[6:0]   = ops[$urandom_range(0, 8)];
            id_inst[19:15] = 5'($urandom_range(0, 3));
            id_inst[24:20] = 5'($urandom_range(0, 3));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_hazard_ctrl.md
# fetch_hazard_ctrl

Pipeline sequencing controller for the fetch stage and the IF/ID and ID/EX pipeline registers. It drives the fetch stage's PC enable, NOP-injection (stall) and jump/branch redirect inputs. It also detects load-use hazards on the instruction in ID and squashes wrong-path instructions after a taken branch/jump resolved in EX. It supports debug halt/resume and keeps saturating stall and flush event counters.

## Interface
Parameters:
- addr_width, `MEM_ADDR_WIDTH, PC/target width
- word_width, `WORD_WIDTH, instruction width (32)
- FLUSH_SLOTS, 1, NOP-fetch cycles after a redirect (1..7)
- CNT_WIDTH, 16, event counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_inst  in  word_width  instruction currently in IF/ID
- ex_rd  in  5  destination register of instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_bch_taken  in  1  EX resolved a taken branch, JAL or JALR this cycle
- ex_bch_tgt  in  addr_width  redirect target from EX
- halt_req  in  1  debug halt request (level)
- resume  in  1  debug resume (pulse)
- pc_en  out  1  PC update enable
- stall_en  out  1  fetch emits NOP instead of memory word
- jmp_bch_en  out  1  select redirect target as next PC
- jmp_bch_tgt  out  addr_width  redirect target
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load bubble into ID/EX
- halted  out  1  controller in HALT
- stall_cnt, flush_cnt  out  CNT_WIDTH each  saturating event counts

## Operation
- States: BOOT, RUN, FLUSH, HALT. Reset enters BOOT and clears the slot counter and both event counters.
- BOOT (one cycle): pc_en=0, stall_en=1, if_id_flush=1, id_ex_flush=1. Always goes to RUN.
- Operand decode of id_inst[6:0]:
  - Uses rs1 and rs2: R-type 0110011, branch 1100011, store 0100011.
  - Uses rs1 only: I-ALU 0010011, load 0000011, JALR 1100111.
  - Uses neither: LUI, AUIPC, JAL, and any other opcode.
  - rs1=id_inst[19:15], rs2=id_inst[24:20].
- load_use = ex_mem_read && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1) || (uses_rs2 && ex_rd==rs2)).
- RUN, priority top-down:
  1. ex_bch_taken:
     - jmp_bch_en=1, jmp_bch_tgt=ex_bch_tgt, pc_en=1, if_id_flush=1, id_ex_flush=1.
     - flush_cnt increments.
     - Goes to FLUSH with slot counter=FLUSH_SLOTS, or stays in RUN if FLUSH_SLOTS=0.
     - Any load_use in the same cycle is ignored.
  2. load_use:
     - pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt increments; state stays RUN.
     - The condition is re-evaluated every cycle.
  3. halt_req: go to HALT at this edge. Outputs this cycle are the normal RUN values.
  4. Otherwise: pc_en=1, if_id_en=1, all other control outputs 0.
- FLUSH:
  - Outputs: pc_en=1, stall_en=1, if_id_en=1, jmp_bch_en=0.
  - The slot counter decrements each cycle; at 1 the state goes to RUN.
  - ex_bch_taken is ignored, because only bubbles reach EX.
- HALT:
  - Outputs: pc_en=0, if_id_en=0, stall_en=1, id_ex_flush=1, halted=1.
  - resume goes to RUN. halt_req is ignored here.
  - A resume and a still-asserted halt_req re-halt after one RUN cycle.
- Default output values: pc_en=0, stall_en=0, jmp_bch_en=0, if_id_en=0, if_id_flush=0, id_ex_flush=0, halted=0. jmp_bch_tgt=ex_bch_tgt at all times.
- Counters saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from state and current inputs. A redirect reaches the PC at the next rising edge, so there is zero added latency.
- State and counters are registered. rst has priority over all inputs.
- Reset values on the cycle after rst: state BOOT, pc_en=0, stall_en=1, if_id_flush=1, id_ex_flush=1, jmp_bch_en=0, if_id_en=0, halted=0, counters=0.
- rst asserted mid-FLUSH or mid-HALT returns to BOOT on the next edge. The slot counter is cleared.
- Load-use stall costs exactly 1 cycle, since the bubble clears ex_mem_read.
- A taken redirect costs 2 squashed instructions plus FLUSH_SLOTS NOP fetches.

## Test plan
- Reset: hold rst 3 cycles, release.
  - Required: BOOT outputs for exactly 1 cycle after release, then RUN with pc_en=1.
  - Counters=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_inst=ADD x6,x5,x7.
  - Required: pc_en=0, if_id_en=0, id_ex_flush=1 for 1 cycle; stall_cnt=1.
  - Repeat with id_inst=LUI x5 and with ex_rd=0: no stall in either case.
- Redirect: ex_bch_taken=1, ex_bch_tgt=0x40, FLUSH_SLOTS=1.
  - Required: jmp_bch_en=1, both flushes=1 that cycle; next cycle stall_en=1, pc_en=1; then RUN.
  - flush_cnt=1.
- Simultaneous: ex_bch_taken=1 with a load_use condition.
  - Required: redirect taken, stall_cnt unchanged, pc_en=1.
- Halt: halt_req=1 in RUN.
  - Required: halted=1 and pc_en=0 from the next cycle.
  - A resume pulse after 5 cycles gives pc_en=1 the cycle after resume.
- Saturation: force 2^CNT_WIDTH+3 stalls (CNT_WIDTH=4 build).
  - Required: stall_cnt holds 0xF.
